// File: rtl/hazard_pkg.sv
// Shared types and control encodings for the ID-stage hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Widest register address a scoreboard entry can hold; narrower
    // REG_AW values are zero-extended into this field.
    localparam int RD_W_MAX = 8;

    typedef struct packed {
        logic                v;
        logic [RD_W_MAX-1:0] rd;
        logic                ld;
    } sb_entry_t;

    typedef struct packed {
        logic pcwrite;
        logic ifid_write;
        logic ctrl_en;
        logic flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = '{pcwrite: 1'b1, ifid_write: 1'b1, ctrl_en: 1'b1, flush: 1'b0};
    localparam ctrl_t CTRL_STALL = '{pcwrite: 1'b0, ifid_write: 1'b0, ctrl_en: 1'b0, flush: 1'b0};
    localparam ctrl_t CTRL_HOLD  = '{pcwrite: 1'b0, ifid_write: 1'b0, ctrl_en: 1'b1, flush: 1'b0};
    localparam ctrl_t CTRL_XFER  = '{pcwrite: 1'b1, ifid_write: 1'b0, ctrl_en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/sb_match.sv
// Compares one scoreboard entry against the ID-stage source registers.
// Latency: combinational.
// Backpressure: none.
// Ports: entry (scoreboard slot), rs/rt + use bits (ID sources), hit (RAW match).
module sb_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  sb_entry_t         entry,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    output logic              hit
);

    logic [RD_W_MAX-1:0] rs_w;
    logic [RD_W_MAX-1:0] rt_w;
    logic                hit_rs;
    logic                hit_rt;

    assign rs_w = RD_W_MAX'(rs);
    assign rt_w = RD_W_MAX'(rt);

    // $0 is hardwired, so a match on it is never a real dependency.
    assign hit_rs = use_rs & entry.v & (entry.rd == rs_w) & (rs != '0);
    assign hit_rt = use_rt & entry.v & (entry.rd == rt_w) & (rt != '0);
    assign hit    = hit_rs | hit_rt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: tracks in-flight destinations, drives stall/bubble/flush, counts stalls.
// Latency: controls combinational from scoreboard + ID inputs; state updates on Clk rise.
// Backpressure: pipe_hold freezes the scoreboard and counters and holds PC/IF-ID.
// Ports: Clk/Reset_n; pipe_hold; id_* (ID instruction); PCWrite/IF_ID_Write/ControlEn/IF_ID_Flush;
//        stall_total, stall_run, watchdog_err (statistics).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int STAGES    = 3,
    parameter int FWD_EN    = 0,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pipe_hold,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_early,
    input  logic              id_jump,
    input  logic              id_jumpreg,
    input  logic              id_branch_taken,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              ControlEn,
    output logic              IF_ID_Flush,
    output logic [CNT_W-1:0]  stall_total,
    output logic [3:0]        stall_run,
    output logic              watchdog_err
);

    localparam logic [3:0] WD_LIMIT = 4'(STAGES + 1);

    sb_entry_t         sb [STAGES];
    sb_entry_t         new_e0;
    logic [STAGES-1:0] hit;
    logic [STAGES-1:0] elig;
    logic [STAGES-1:0] hit_ok;
    logic              stall_raw;
    logic              stall;
    logic              xfer;
    ctrl_t             ctrl;
    logic [3:0]        run_nxt;

    for (genvar k = 0; k < STAGES; k++) begin : g_match
        sb_match #(.REG_AW(REG_AW)) u_match (
            .entry  (sb[k]),
            .rs     (id_rs),
            .rt     (id_rt),
            .use_rs (id_use_rs),
            .use_rt (id_use_rt),
            .hit    (hit[k])
        );
        // With write-before-read the oldest entry's value is already visible.
        assign elig[k] = !((WB_BYPASS != 0) && (k == STAGES - 1));
    end

    assign hit_ok = hit & elig;

    // With forwarding, only a load result (or any result needed in ID) one
    // stage ahead, or a load two stages ahead needed in ID, cannot be bypassed.
    always_comb begin
        stall_raw = 1'b0;
        if (FWD_EN == 0) begin
            stall_raw = |hit_ok;
        end else begin
            stall_raw = (hit_ok[0] & (sb[0].ld | id_early))
                      | (hit_ok[1] & sb[1].ld & id_early);
        end
    end

    assign stall = id_valid & stall_raw;
    assign xfer  = id_valid & (id_jump | id_jumpreg | id_branch_taken);

    always_comb begin
        ctrl = CTRL_RUN;
        if (!Reset_n)       ctrl = '0;
        else if (pipe_hold) ctrl = CTRL_HOLD;
        else if (stall)     ctrl = CTRL_STALL;
        else if (xfer)      ctrl = CTRL_XFER;
    end

    assign PCWrite     = ctrl.pcwrite;
    assign IF_ID_Write = ctrl.ifid_write;
    assign ControlEn   = ctrl.ctrl_en;
    assign IF_ID_Flush = ctrl.flush;

    // A stalled instruction stays in ID, so the slot entering EX is a bubble.
    always_comb begin
        new_e0.v  = ~stall & id_valid & id_regwrite & (id_rd != '0);
        new_e0.rd = RD_W_MAX'(id_rd);
        new_e0.ld = id_memread;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < STAGES; k++) sb[k] <= '0;
        end else if (!pipe_hold) begin
            sb[0] <= new_e0;
            for (int k = 1; k < STAGES; k++) sb[k] <= sb[k-1];
        end
    end

    always_comb begin
        run_nxt = 4'd0;
        if (pipe_hold)  run_nxt = stall_run;
        else if (stall) run_nxt = (stall_run == 4'hF) ? stall_run : stall_run + 4'd1;
    end

    // A legitimate RAW never stalls longer than STAGES cycles, so a run
    // beyond that means the scoreboard or pipeline has lost track.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_total  <= '0;
            stall_run    <= '0;
            watchdog_err <= 1'b0;
        end else begin
            stall_total  <= stall_total + CNT_W'(stall & ~pipe_hold);
            stall_run    <= run_nxt;
            watchdog_err <= watchdog_err | (run_nxt == WD_LIMIT);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam logic [3:0] RUN = 4'b1110;  // {PCWrite, IF_ID_Write, ControlEn, IF_ID_Flush}
    localparam logic [3:0] STL = 4'b0000;
    localparam logic [3:0] HLD = 4'b0010;
    localparam logic [3:0] XFR = 4'b1011;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       pipe_hold = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic       id_regwrite = 1'b0, id_memread = 1'b0, id_early = 1'b0;
    logic       id_jump = 1'b0, id_jumpreg = 1'b0, id_branch_taken = 1'b0;

    logic        pcw0, ifw0, ce0, fl0, wd0;
    logic        pcw1, ifw1, ce1, fl1, wd1;
    logic [31:0] tot0, tot1;
    logic [3:0]  run0, run1;

    always #5 Clk = ~Clk;

    hazard_scoreboard #(.REG_AW(5), .STAGES(3), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(32)) u_dut_fwd0 (
        .Clk(Clk), .Reset_n(Reset_n), .pipe_hold(pipe_hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_early(id_early),
        .id_jump(id_jump), .id_jumpreg(id_jumpreg), .id_branch_taken(id_branch_taken),
        .PCWrite(pcw0), .IF_ID_Write(ifw0), .ControlEn(ce0), .IF_ID_Flush(fl0),
        .stall_total(tot0), .stall_run(run0), .watchdog_err(wd0)
    );

    hazard_scoreboard #(.REG_AW(5), .STAGES(3), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(32)) u_dut_fwd1 (
        .Clk(Clk), .Reset_n(Reset_n), .pipe_hold(pipe_hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_early(id_early),
        .id_jump(id_jump), .id_jumpreg(id_jumpreg), .id_branch_taken(id_branch_taken),
        .PCWrite(pcw1), .IF_ID_Write(ifw1), .ControlEn(ce1), .IF_ID_Flush(fl1),
        .stall_total(tot1), .stall_run(run1), .watchdog_err(wd1)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [31:0] exp_tot0 = '0, exp_tot1 = '0;
    logic [3:0]  exp_run0 = '0, exp_run1 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] run_upd(input logic [3:0] r, input logic [3:0] e, input logic hold);
        if (hold)           return r;
        else if (e == STL)  return (r == 4'hF) ? r : r + 4'd1;
        else                return 4'd0;
    endfunction

    // xf: 0 none, 1 jr, 2 jump, 3 taken branch
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic early, input logic [1:0] xf);
        id_valid = 1'b1;
        id_rs = rs; id_use_rs = 1'b1;
        id_rt = rt; id_use_rt = 1'b1;
        id_rd = rd; id_regwrite = rw; id_memread = mr; id_early = early;
        id_jumpreg = (xf == 2'd1);
        id_jump = (xf == 2'd2);
        id_branch_taken = (xf == 2'd3);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_regwrite = 1'b0; id_memread = 1'b0; id_early = 1'b0;
        id_jump = 1'b0; id_jumpreg = 1'b0; id_branch_taken = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ctrl0"}, 32'({pcw0, ifw0, ce0, fl0}), 32'h0);
        check({tag, ".ctrl1"}, 32'({pcw1, ifw1, ce1, fl1}), 32'h0);
        check({tag, ".tot0"}, tot0, 32'h0);
        check({tag, ".tot1"}, tot1, 32'h0);
        check({tag, ".run0"}, 32'(run0), 32'h0);
        check({tag, ".run1"}, 32'(run1), 32'h0);
        check({tag, ".wd0"}, 32'(wd0), 32'h0);
        check({tag, ".wd1"}, 32'(wd1), 32'h0);
    endtask

    // One ID cycle: expected controls queued with the stimulus, compared at negedge.
    task automatic step(input string tag, input logic [3:0] e0, input logic [3:0] e1);
        logic [7:0] ex;
        exp_q.push_back({e0, e1});
        @(negedge Clk);
        ex = exp_q.pop_front();
        check({tag, ".ctrl0"}, 32'({pcw0, ifw0, ce0, fl0}), 32'(ex[7:4]));
        check({tag, ".ctrl1"}, 32'({pcw1, ifw1, ce1, fl1}), 32'(ex[3:0]));
        check({tag, ".tot0"}, tot0, exp_tot0);
        check({tag, ".tot1"}, tot1, exp_tot1);
        check({tag, ".run0"}, 32'(run0), 32'(exp_run0));
        check({tag, ".run1"}, 32'(run1), 32'(exp_run1));
        check({tag, ".wd0"}, 32'(wd0), 32'h0);
        check({tag, ".wd1"}, 32'(wd1), 32'h0);
        if (!pipe_hold && ex[7:4] == STL) exp_tot0 = exp_tot0 + 32'd1;
        if (!pipe_hold && ex[3:0] == STL) exp_tot1 = exp_tot1 + 32'd1;
        exp_run0 = run_upd(exp_run0, ex[7:4], pipe_hold);
        exp_run1 = run_upd(exp_run1, ex[3:0], pipe_hold);
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) step("drain", RUN, RUN);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        #2;
        check_reset_vals("reset");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // add $5 ; sub reads $5
        drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0);  step("t1.add", RUN, RUN);
        drive(5'd5, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0); step("t1.sub_a", STL, RUN);
        step("t1.sub_b", STL, RUN);
        step("t1.sub_c", RUN, RUN);
        drain();

        // lw $8 ; add reads $8 through rt
        drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 2'd0);  step("t2.lw", RUN, RUN);
        drive(5'd2, 5'd8, 5'd11, 1'b1, 1'b0, 1'b0, 2'd0); step("t2.add_a", STL, STL);
        step("t2.add_b", STL, RUN);
        step("t2.add_c", RUN, RUN);
        drain();

        // lw $9 ; jr $9
        drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 2'd0);  step("t3.lw", RUN, RUN);
        drive(5'd9, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1);  step("t3.jr_a", STL, STL);
        step("t3.jr_b", STL, STL);
        step("t3.jr_c", XFR, XFR);
        drain();

        // writes to $0 and non-writing producers never stall
        drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0);  step("t4.lw0", RUN, RUN);
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 2'd3);  step("t4.beq0", XFR, XFR);
        drive(5'd1, 5'd2, 5'd7, 1'b0, 1'b1, 1'b0, 2'd0);  step("t4.nowr", RUN, RUN);
        drive(5'd7, 5'd7, 5'd4, 1'b1, 1'b0, 1'b1, 2'd0);  step("t4.rd7", RUN, RUN);
        drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2);  step("t4.j", XFR, XFR);
        drain();

        // external hold over a pending hazard
        drive(5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0, 2'd0); step("t5.lw", RUN, RUN);
        drive(5'd12, 5'd2, 5'd14, 1'b1, 1'b0, 1'b0, 2'd0);
        pipe_hold = 1'b1;
        repeat (3) step("t5.hold", HLD, HLD);
        pipe_hold = 1'b0;
        step("t5.rel_a", STL, STL);
        step("t5.rel_b", STL, RUN);
        step("t5.rel_c", RUN, RUN);
        drain();

        // reset pulled in the middle of a stall
        drive(5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b0, 2'd0); step("t6.lw", RUN, RUN);
        drive(5'd13, 5'd2, 5'd15, 1'b1, 1'b0, 1'b0, 2'd0); step("t6.stall", STL, STL);
        #2 Reset_n = 1'b0;
        #1;
        check_reset_vals("t6.rst");
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        exp_tot0 = '0; exp_tot1 = '0; exp_run0 = '0; exp_run1 = '0;
        step("t6.after", RUN, RUN);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core, sitting beside the ID stage. It keeps its own shift-register scoreboard of in-flight destination registers instead of taking per-stage Rd/RegWrite inputs. From that scoreboard it drives PC/IF-ID stall, bubble insertion and control-transfer flush, with a selectable forwarding mode. It also keeps stall statistics and flags a watchdog error when a stall lasts longer than the pipeline can explain.

## Interface
- REG_AW, 5, register-address width
- STAGES, 3, tracked stages after ID (entry 0 = ID/EX … entry STAGES-1 = MEM/WB); legal 2..8
- FWD_EN, 0, 0 = stall on any RAW; 1 = forwarding present, stall only where forwarding cannot help
- WB_BYPASS, 1, 1 = register file write-before-read, so entry STAGES-1 never causes a hazard
- CNT_W, 32, width of total-stall counter
- Clk  input  1  clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- pipe_hold  input  1  external freeze (memory busy)
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt  input  REG_AW  source registers
- id_use_rs, id_use_rt  input  1  source actually read
- id_rd  input  REG_AW  destination
- id_regwrite, id_memread  input  1  writes a register / is a load
- id_early  input  1  operands consumed in ID (branch, jr)
- id_jump, id_jumpreg, id_branch_taken  input  1  control transfer resolved in ID
- PCWrite, IF_ID_Write, ControlEn, IF_ID_Flush  output  1  pipeline controls
- stall_total  output  CNT_W  cumulative stall cycles
- stall_run  output  4  current consecutive stall length, saturating at 15
- watchdog_err  output  1  sticky

## Operation
- Scoreboard entry fields: {v, rd, ld}.
- An ID source matches entry k when all hold: use bit = 1, entry v = 1, rd equal, rd ≠ 0.
- Entries excluded from matching when WB_BYPASS = 1: entry STAGES-1.
- stall condition, FWD_EN = 0: any source matches any non-excluded entry.
- stall condition, FWD_EN = 1: any of the following:
  - match on e0 with (e0.ld | id_early)
  - match on e1 with e1.ld & id_early
- All stall terms are gated by id_valid.
- Priority: hold > stall > xfer.
  - xfer = id_valid & (id_jump | id_jumpreg | id_branch_taken).
- Output values per condition:
  - hold: PCWrite=0, IF_ID_Write=0, ControlEn=1, Flush=0; scoreboard frozen.
  - stall: PCWrite=0, IF_ID_Write=0, ControlEn=0 (bubble), Flush=0.
  - xfer: PCWrite=1, IF_ID_Write=0, ControlEn=1, Flush=1.
  - otherwise: 1, 1, 1, 0.
- jr/branch with a pending hazard stalls first; it redirects and flushes only in the first hazard-free cycle.
- Scoreboard update, when not hold: e[k] ← e[k-1]. The new e0 is:
  - stall: v = 0;
  - otherwise: v = id_valid & id_regwrite & (id_rd ≠ 0), rd = id_rd, ld = id_memread.
- stall_total increments on each stall cycle (not hold) and wraps modulo 2^CNT_W.
- stall_run: increments on stall and saturates at 15. It clears on a non-stall, non-hold cycle and holds during hold.
- watchdog_err sets when stall_run reaches STAGES + 1. It stays set until reset.

## Timing
- Control outputs are combinational from the current scoreboard and ID inputs, valid in the same cycle.
- Scoreboard and counters update on the rising Clk edge.
- While Reset_n = 0:
  - PCWrite=0, IF_ID_Write=0, ControlEn=0, IF_ID_Flush=0;
  - all entries v = 0;
  - stall_total = 0, stall_run = 0, watchdog_err = 0.
- Reset asserted mid-stall discards all entries. The first cycle after release sees an empty scoreboard, so no stall.
- A load followed by a dependent ALU op, FWD_EN = 1: exactly 1 stall cycle.
- Any RAW, FWD_EN = 0: at most STAGES − WB_BYPASS stall cycles.

## Structure
- Shared package `hazard_pkg` holds:
  - the scoreboard entry struct {v, rd, ld};
  - the control-bundle struct {pcwrite, ifid_write, ctrl_en, flush};
  - constants CTRL_RUN, CTRL_STALL, CTRL_HOLD, CTRL_XFER.
- One sub-module, `sb_match`: combinational compare of one entry against rs/rt. It is instantiated STAGES times.

## Test plan
- FWD_EN=0, STAGES=3, WB_BYPASS=1.
  - Stimulus: `add $5` then `sub` reading $5.
  - Required: 2 stall cycles (ControlEn=0, PCWrite=0), then run; stall_total=2.
- FWD_EN=1.
  - Stimulus: `lw $8` then `add` reading $8.
  - Required: 1 stall cycle; in the same case a non-load producer gives 0 stalls.
- FWD_EN=1.
  - Stimulus: `lw $9` then `jr $9` (id_early).
  - Required: 2 stalls, then a cycle with Flush=1, PCWrite=1, IF_ID_Write=0.
- Stimulus: writes to $0, and id_regwrite=0 with matching rd.
  - Required: never stall.
- Stimulus: pipe_hold=1 for 3 cycles during a pending hazard.
  - Required: scoreboard frozen, stall_total unchanged, hazard resumes after release.
- Stimulus: Reset_n pulled low mid-stall.
  - Required: outputs go to 0 immediately and counters clear. After release, run values apply and watchdog_err=0.
